// File: rtl/pht_update_queue.sv
// pht_update_queue: in-order queue of predicted branches that trains the PHT on resolution.
module pht_update_queue #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic                       req_pred,
  output logic                       req_ready,
  input  logic                       resolve_valid,
  input  logic                       resolve_taken,
  input  logic                       flush,
  output logic                       upd_result,
  output logic [ADDR_W-1:0]          upd_addr,
  output logic                       upd_taken,
  output logic                       mispredict,
  output logic [$clog2(DEPTH):0]     count,
  output logic [15:0]                mispredict_count,
  output logic                       underflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic              pred_mem [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic              push, pop, empty;
  assign req_ready = count != CW'(DEPTH);
  assign empty     = count == '0;
  assign push      = req_valid && req_ready && !flush;
  assign pop       = resolve_valid && !empty && !flush;
  always_ff @(posedge clk)
    if (push) begin
      addr_mem[wr_ptr] <= req_addr;
      pred_mem[wr_ptr] <= req_pred;
    end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      count            <= '0;
      upd_result       <= 1'b0;
      upd_addr         <= '0;
      upd_taken        <= 1'b0;
      mispredict       <= 1'b0;
      mispredict_count <= '0;
      underflow        <= 1'b0;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
      upd_result <= pop;
      mispredict <= pop && (pred_mem[rd_ptr] != resolve_taken);
      if (pop) begin
        upd_addr  <= addr_mem[rd_ptr];
        upd_taken <= resolve_taken;
      end
      if (mispredict && mispredict_count != 16'hFFFF) mispredict_count <= mispredict_count + 16'd1;
      if (resolve_valid && empty && !flush) underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pht_update_queue.sv
// tb_pht_update_queue: directed vector table plus hand-written saturation and reset sequences.
module tb_pht_update_queue;
  logic        clk = 1'b0;
  logic        reset, req_valid, req_pred, resolve_valid, resolve_taken, flush;
  logic [7:0]  req_addr;
  logic        req_ready, upd_result, upd_taken, mispredict, underflow;
  logic [7:0]  upd_addr;
  logic [2:0]  count;
  logic [15:0] mispredict_count;
  int checks = 0;
  int failures = 0;

  pht_update_queue #(.ADDR_W(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr), .req_pred(req_pred),
    .req_ready(req_ready), .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .flush(flush),
    .upd_result(upd_result), .upd_addr(upd_addr), .upd_taken(upd_taken), .mispredict(mispredict),
    .count(count), .mispredict_count(mispredict_count), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, rv;
    logic [7:0] ra;
    logic rp, sv, st, fl;
    logic eur;
    logic [7:0] eua;
    logic eut, emp;
    logic [2:0] ecnt;
    logic erdy, euf;
    logic [15:0] emc;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input int rst, rv, ra, rp, sv, st, fl, eur, eua, eut, emp, ecnt, erdy, euf, emc);
    vec_t v;
    v.rst = rst[0]; v.rv = rv[0]; v.ra = ra[7:0]; v.rp = rp[0]; v.sv = sv[0]; v.st = st[0]; v.fl = fl[0];
    v.eur = eur[0]; v.eua = eua[7:0]; v.eut = eut[0]; v.emp = emp[0]; v.ecnt = ecnt[2:0];
    v.erdy = erdy[0]; v.euf = euf[0]; v.emc = emc[15:0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, rv, input logic [7:0] ra, input logic rp, sv, st, fl);
    reset = rst; req_valid = rv; req_addr = ra; req_pred = rp;
    resolve_valid = sv; resolve_taken = st; flush = fl;
    @(negedge clk);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);
    // rst rv ra rp sv st fl | ur ua ut mp cnt rdy uf mc
    vecs.push_back(mk(1,0,0,0,0,0,0,       0,0,0,0,0,1,0,0));
    vecs.push_back(mk(0,1,'h12,1,0,0,0,    0,0,0,0,1,1,0,0));
    vecs.push_back(mk(0,0,0,0,1,1,0,       1,'h12,1,0,0,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,       0,0,0,0,0,1,0,0));
    vecs.push_back(mk(0,1,'h01,1,0,0,0,    0,0,0,0,1,1,0,0));
    vecs.push_back(mk(0,1,'h02,0,0,0,0,    0,0,0,0,2,1,0,0));
    vecs.push_back(mk(0,1,'h03,1,0,0,0,    0,0,0,0,3,1,0,0));
    vecs.push_back(mk(0,1,'h04,0,0,0,0,    0,0,0,0,4,0,0,0));
    vecs.push_back(mk(0,1,'h05,1,0,0,0,    0,0,0,0,4,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,0,0,       1,'h01,0,1,3,1,0,0));
    vecs.push_back(mk(0,0,0,0,1,0,0,       1,'h02,0,0,2,1,0,1));
    vecs.push_back(mk(0,0,0,0,1,0,0,       1,'h03,0,1,1,1,0,1));
    vecs.push_back(mk(0,0,0,0,1,0,0,       1,'h04,0,0,0,1,0,2));
    vecs.push_back(mk(0,1,'h41,0,0,0,0,    0,0,0,0,1,1,0,2));
    vecs.push_back(mk(0,1,'h42,1,0,0,0,    0,0,0,0,2,1,0,2));
    vecs.push_back(mk(0,1,'h43,0,0,0,0,    0,0,0,0,3,1,0,2));
    vecs.push_back(mk(0,1,'h44,1,0,0,0,    0,0,0,0,4,0,0,2));
    vecs.push_back(mk(0,1,'h45,1,1,1,0,    1,'h41,1,1,3,1,0,2));
    vecs.push_back(mk(0,1,'h50,1,1,1,0,    1,'h42,1,0,3,1,0,3));
    vecs.push_back(mk(0,1,'h51,1,1,1,0,    1,'h43,1,1,3,1,0,3));
    vecs.push_back(mk(0,1,'h52,1,1,1,0,    1,'h44,1,0,3,1,0,4));
    vecs.push_back(mk(0,1,'h53,1,1,1,0,    1,'h50,1,0,3,1,0,4));
    vecs.push_back(mk(0,1,'h54,1,1,1,0,    1,'h51,1,0,3,1,0,4));
    vecs.push_back(mk(0,1,'h55,1,1,1,0,    1,'h52,1,0,3,1,0,4));
    vecs.push_back(mk(0,0,0,0,1,1,0,       1,'h53,1,0,2,1,0,4));
    vecs.push_back(mk(0,0,0,0,1,1,0,       1,'h54,1,0,1,1,0,4));
    vecs.push_back(mk(0,0,0,0,1,1,0,       1,'h55,1,0,0,1,0,4));
    vecs.push_back(mk(0,1,'h60,1,0,0,0,    0,0,0,0,1,1,0,4));
    vecs.push_back(mk(0,1,'h61,1,0,0,0,    0,0,0,0,2,1,0,4));
    vecs.push_back(mk(0,1,'h62,1,0,0,0,    0,0,0,0,3,1,0,4));
    vecs.push_back(mk(0,0,0,0,1,0,1,       0,0,0,0,0,1,0,4));
    vecs.push_back(mk(0,1,'h30,1,0,0,0,    0,0,0,0,1,1,0,4));
    vecs.push_back(mk(0,0,0,0,1,1,0,       1,'h30,1,0,0,1,0,4));
    vecs.push_back(mk(0,1,'h70,0,0,0,0,    0,0,0,0,1,1,0,4));
    vecs.push_back(mk(0,0,0,0,1,1,0,       1,'h70,1,1,0,1,0,4));
    vecs.push_back(mk(0,1,'h71,0,1,1,1,    0,0,0,0,0,1,0,5));
    vecs.push_back(mk(0,1,'h20,0,1,0,0,    0,0,0,0,1,1,1,5));
    vecs.push_back(mk(0,0,0,0,1,0,0,       1,'h20,0,0,0,1,1,5));
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].rv, vecs[i].ra, vecs[i].rp, vecs[i].sv, vecs[i].st, vecs[i].fl);
      chk($sformatf("v%0d.upd_result", i), 32'(upd_result), 32'(vecs[i].eur));
      if (vecs[i].eur) begin
        chk($sformatf("v%0d.upd_addr", i), 32'(upd_addr), 32'(vecs[i].eua));
        chk($sformatf("v%0d.upd_taken", i), 32'(upd_taken), 32'(vecs[i].eut));
      end
      chk($sformatf("v%0d.mispredict", i), 32'(mispredict), 32'(vecs[i].emp));
      chk($sformatf("v%0d.count", i), 32'(count), 32'(vecs[i].ecnt));
      chk($sformatf("v%0d.req_ready", i), 32'(req_ready), 32'(vecs[i].erdy));
      chk($sformatf("v%0d.underflow", i), 32'(underflow), 32'(vecs[i].euf));
      chk($sformatf("v%0d.mispredict_count", i), 32'(mispredict_count), 32'(vecs[i].emc));
    end
    // Stream mispredicting branches through a one-deep backlog to approach saturation.
    drive(0, 1, 8'h80, 0, 0, 0, 0);
    for (int i = 0; i < 65529; i++) drive(0, 1, 8'h81, 0, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("sat.mcount_fffe", 32'(mispredict_count), 32'hFFFE);
    chk("sat.count_1", 32'(count), 32'd1);
    for (int i = 0; i < 3; i++) drive(0, 1, 8'h82, 0, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("sat.mcount_ffff", 32'(mispredict_count), 32'hFFFF);
    drive(0, 1, 8'h83, 1, 0, 0, 0);
    chk("rst.count_before", 32'(count), 32'd2);
    drive(1, 0, 0, 0, 1, 1, 0);
    chk("rst.upd_result", 32'(upd_result), 32'd0);
    chk("rst.upd_addr", 32'(upd_addr), 32'd0);
    chk("rst.upd_taken", 32'(upd_taken), 32'd0);
    chk("rst.mispredict", 32'(mispredict), 32'd0);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.req_ready", 32'(req_ready), 32'd1);
    chk("rst.mcount", 32'(mispredict_count), 32'd0);
    chk("rst.underflow", 32'(underflow), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("post_rst.upd_result", 32'(upd_result), 32'd0);
    chk("post_rst.count", 32'(count), 32'd0);
    chk("post_rst.mcount", 32'(mispredict_count), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pht_update_queue.md
# pht_update_queue

Tracks in-flight conditional branches between the prediction lookup and branch resolution, then drives the training update back into the pattern history table. At lookup time it records each branch's PHT index and predicted direction in an in-order queue. When the oldest branch resolves, it presents the PHT update strobe with the same index and the actual outcome, and flags and counts mispredictions. It sits between the fetch/predict stage and the execute stage's branch resolution.

## Interface
- `ADDR_W`, default 8: PHT index width.
- `DEPTH`, default 4: maximum outstanding branches; a power of two, at least 2.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `req_valid` input 1: a branch was predicted this cycle.
- `req_addr` input `ADDR_W`: PHT index used for the lookup.
- `req_pred` input 1: predicted direction returned by the PHT (1 = taken).
- `req_ready` output 1: queue can accept a branch; equals `count != DEPTH`.
- `resolve_valid` input 1: the oldest outstanding branch resolved this cycle.
- `resolve_taken` input 1: actual branch outcome.
- `flush` input 1: discard all outstanding branches (pipeline squash).
- `upd_result` output 1: one-cycle PHT update strobe, registered.
- `upd_addr` output `ADDR_W`: PHT index to train, registered.
- `upd_taken` output 1: actual outcome to train with, registered.
- `mispredict` output 1: one-cycle pulse aligned with `upd_result` when the prediction was wrong.
- `count` output `$clog2(DEPTH)+1`: number of outstanding entries.
- `mispredict_count` output 16: saturating count of mispredictions.
- `underflow` output 1: sticky flag, set by a resolve while the queue is empty.

## Operation
- Storage: circular buffer of `DEPTH` entries, each holding `{addr, pred}`. Read pointer `rd_ptr` and write pointer `wr_ptr` are each `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. `count` is held in a separate register.
- Push: when `req_valid && req_ready`, write the entry at `wr_ptr`, then increment `wr_ptr`. If `req_valid` is high while full, the request is dropped and nothing changes.
- `req_ready` is computed from the registered `count` only. A pop in the same cycle does not free a slot for that cycle's push.
- Pop: when `resolve_valid` and `count != 0`, read the entry at `rd_ptr`, then increment `rd_ptr`. Next cycle:
  - `upd_result` = 1
  - `upd_addr` = entry addr
  - `upd_taken` = `resolve_taken`
  - `mispredict` = (entry pred != `resolve_taken`)
- Resolve while empty, including the same cycle as the first push: no pop, no update, `underflow` is set to 1. The pushed entry is still accepted.
- Simultaneous push and pop (not full, not empty): both take effect and `count` is unchanged.
- `flush` takes priority over push and pop:
  - next cycle, `count` = 0 and `rd_ptr = wr_ptr = 0`
  - no update is issued for that cycle's resolve
  - `underflow` is not set
  - `upd_result` output from a pop in the previous cycle is unaffected
- `mispredict_count` increments on each `mispredict` pulse and holds at `16'hFFFF`.
- `underflow` is cleared only by `reset`.
- Reset values: pointers 0, `count` 0, `upd_result` 0, `upd_addr` 0, `upd_taken` 0, `mispredict` 0, `mispredict_count` 0, `underflow` 0, `req_ready` 1. Entry contents are don't-care.
- A reset asserted mid-operation discards all outstanding entries, and no update is emitted for them.

## Timing
- Push to `count` visible: 1 cycle.
- Resolve to `upd_result`, `upd_addr`, `upd_taken`, `mispredict`: exactly 1 cycle.
- Outputs are registered, and `upd_*` outputs are valid only while `upd_result` = 1.
- `upd_result` is high for 1 cycle per pop. Back-to-back resolves produce back-to-back update strobes.
- `mispredict_count` reflects a misprediction 2 cycles after the resolve, i.e. the cycle after the `mispredict` pulse.
- No combinational path from any input to any output except `req_ready`, which depends on the `count` register only.

## Test plan
- Reset, then push addr 0x12 with pred 1, then resolve with taken 1 -> one cycle later: `upd_result`=1, `upd_addr`=0x12, `upd_taken`=1, `mispredict`=0, `count`=0.
- Push 4 entries (0x01..0x04, preds 1,0,1,0), then a fifth with addr 0x05 -> `req_ready`=0 after the fourth and 0x05 is dropped. Four resolves with taken 0 produce updates in order 0x01..0x04, `mispredict` pulses for 0x01 and 0x03, and `mispredict_count`=2.
- Full queue with push and resolve in the same cycle -> push dropped, 1 update emitted, `count`=3. Then 6 alternating push/pop cycles -> pointers wrap and update order matches push order.
- Resolve while empty, simultaneous with push of 0x20 -> no `upd_result`, `underflow`=1, `count`=1. Next resolve updates 0x20.
- Push 3 entries, then `flush` together with a resolve -> no update, `count`=0, `underflow`=0. A subsequent push of 0x30 and resolve produce an update with `upd_addr`=0x30.
- Force `mispredict_count` to 0xFFFE via 65534 mispredictions, then apply 3 more -> count holds at 0xFFFF. Then assert `reset` mid-queue with `count`=2 -> all outputs return to their reset values and no update follows.
